// File: rtl/div_share_scheduler.sv
// div_share_scheduler
// Shares one 8-bit divider between NREQ requesters using round-robin arbitration.
// One operation is in flight at a time. A zero divisor is answered locally
// without launching the divider. A watchdog aborts the operation if the
// divider's busy handshake never completes.

module div_share_scheduler #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_dividend,
   input  logic [8*NREQ-1:0] req_divisor,
   output logic [NREQ-1:0]   gnt,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        rsp_quotient,
   output logic [7:0]        rsp_remainder,
   output logic              rsp_dbz,
   output logic              rsp_err,
   output logic              div_start,
   output logic [7:0]        div_dividend,
   output logic [7:0]        div_divisor,
   input  logic              div_busy,
   input  logic [7:0]        div_quotient,
   input  logic [7:0]        div_remainder
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;
   logic [7:0]        rsp_quotient_q, rsp_quotient_d;
   logic [7:0]        rsp_remainder_q, rsp_remainder_d;
   logic              rsp_dbz_q, rsp_dbz_d;
   logic              rsp_err_q, rsp_err_d;
   logic [7:0]        div_dividend_q, div_dividend_d;
   logic [7:0]        div_divisor_q, div_divisor_d;
   logic              seen_busy_q, seen_busy_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic              win_found;
   logic [IDW-1:0]    win_idx;
   logic [NREQ-1:0]   win_onehot;
   logic [7:0]        win_dividend;
   logic [7:0]        win_divisor;

   logic              hi_found;
   logic [IDW-1:0]    hi_idx;
   logic [7:0]        hi_dividend;
   logic [7:0]        hi_divisor;
   logic              lo_found;
   logic [IDW-1:0]    lo_idx;
   logic [7:0]        lo_dividend;
   logic [7:0]        lo_divisor;

   // Round-robin pick: lowest requester above ptr wins, otherwise lowest overall (wrap)
   always_comb begin
      hi_found    = 1'b0;
      hi_idx      = '0;
      hi_dividend = '0;
      hi_divisor  = '0;
      lo_found    = 1'b0;
      lo_idx      = '0;
      lo_dividend = '0;
      lo_divisor  = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_found    = 1'b1;
            lo_idx      = IDW'(i);
            lo_dividend = req_dividend[8*i +: 8];
            lo_divisor  = req_divisor[8*i +: 8];
            if (i > int'(ptr_q)) begin
               hi_found    = 1'b1;
               hi_idx      = IDW'(i);
               hi_dividend = req_dividend[8*i +: 8];
               hi_divisor  = req_divisor[8*i +: 8];
            end
         end
      end
      win_found    = hi_found | lo_found;
      win_idx      = hi_found ? hi_idx      : lo_idx;
      win_dividend = hi_found ? hi_dividend : lo_dividend;
      win_divisor  = hi_found ? hi_divisor  : lo_divisor;
      win_onehot   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_found && (win_idx == IDW'(i))) begin
            win_onehot[i] = 1'b1;
         end
      end
   end

   // Next-state and next-output computation for the IDLE/ISSUE/RUN sequencer
   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      gnt_d           = '0;
      rsp_valid_d     = 1'b0;
      rsp_id_d        = rsp_id_q;
      rsp_quotient_d  = rsp_quotient_q;
      rsp_remainder_d = rsp_remainder_q;
      rsp_dbz_d       = rsp_dbz_q;
      rsp_err_d       = rsp_err_q;
      div_dividend_d  = div_dividend_q;
      div_divisor_d   = div_divisor_q;
      seen_busy_d     = seen_busy_q;
      cnt_d           = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               gnt_d          = win_onehot;
               rsp_id_d       = win_idx;
               ptr_d          = win_idx;
               div_dividend_d = win_dividend;
               div_divisor_d  = win_divisor;
               state_d        = ISSUE;
            end
         end
         ISSUE: begin
            if (div_divisor_q == 8'd0) begin
               rsp_valid_d     = 1'b1;
               rsp_dbz_d       = 1'b1;
               rsp_err_d       = 1'b0;
               rsp_quotient_d  = 8'hFF;
               rsp_remainder_d = 8'hFF;
               state_d         = IDLE;
            end else begin
               seen_busy_d = 1'b0;
               cnt_d       = '0;
               state_d     = RUN;
            end
         end
         RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (div_busy) begin
               seen_busy_d = 1'b1;
            end
            if (seen_busy_q && !div_busy) begin
               rsp_valid_d     = 1'b1;
               rsp_dbz_d       = 1'b0;
               rsp_err_d       = 1'b0;
               rsp_quotient_d  = div_quotient;
               rsp_remainder_d = div_remainder;
               state_d         = IDLE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rsp_valid_d     = 1'b1;
               rsp_dbz_d       = 1'b0;
               rsp_err_d       = 1'b1;
               rsp_quotient_d  = 8'hFF;
               rsp_remainder_d = 8'hFF;
               state_d         = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any operation in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         ptr_q           <= IDW'(NREQ - 1);
         gnt_q           <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_id_q        <= '0;
         rsp_quotient_q  <= '0;
         rsp_remainder_q <= '0;
         rsp_dbz_q       <= 1'b0;
         rsp_err_q       <= 1'b0;
         div_dividend_q  <= '0;
         div_divisor_q   <= '0;
         seen_busy_q     <= 1'b0;
         cnt_q           <= '0;
      end else begin
         state_q         <= state_d;
         ptr_q           <= ptr_d;
         gnt_q           <= gnt_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_id_q        <= rsp_id_d;
         rsp_quotient_q  <= rsp_quotient_d;
         rsp_remainder_q <= rsp_remainder_d;
         rsp_dbz_q       <= rsp_dbz_d;
         rsp_err_q       <= rsp_err_d;
         div_dividend_q  <= div_dividend_d;
         div_divisor_q   <= div_divisor_d;
         seen_busy_q     <= seen_busy_d;
         cnt_q           <= cnt_d;
      end
   end

   // The divider start is a single-cycle strobe during ISSUE, suppressed for a zero divisor
   always_comb begin
      div_start = (state_q == ISSUE) && (div_divisor_q != 8'd0);
   end

   assign gnt           = gnt_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_id        = rsp_id_q;
   assign rsp_quotient  = rsp_quotient_q;
   assign rsp_remainder = rsp_remainder_q;
   assign rsp_dbz       = rsp_dbz_q;
   assign rsp_err       = rsp_err_q;
   assign div_dividend  = div_dividend_q;
   assign div_divisor   = div_divisor_q;

endmodule

// File: tb/tb_div_share_scheduler.sv
// tb_div_share_scheduler
// Directed bench for div_share_scheduler with a behavioural divider model that
// can also be told to hang with busy stuck high or never rising.

module tb_div_share_scheduler;

   localparam int NREQ    = 4;
   localparam int IDW     = 2;
   localparam int TIMEOUT = 16;

   logic              clk;
   logic              reset;
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_dividend;
   logic [8*NREQ-1:0] req_divisor;
   logic [NREQ-1:0]   gnt;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [7:0]        rsp_quotient;
   logic [7:0]        rsp_remainder;
   logic              rsp_dbz;
   logic              rsp_err;
   logic              div_start;
   logic [7:0]        div_dividend;
   logic [7:0]        div_divisor;
   logic              div_busy;
   logic [7:0]        div_quotient;
   logic [7:0]        div_remainder;

   int assertCount = 0;
   int failCount   = 0;
   int hangMode    = 0;

   logic [3:0] mCnt;
   logic [7:0] mA;
   logic [7:0] mB;

   div_share_scheduler #(
      .NREQ(NREQ),
      .IDW(IDW),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .req_dividend(req_dividend),
      .req_divisor(req_divisor),
      .gnt(gnt),
      .rsp_valid(rsp_valid),
      .rsp_id(rsp_id),
      .rsp_quotient(rsp_quotient),
      .rsp_remainder(rsp_remainder),
      .rsp_dbz(rsp_dbz),
      .rsp_err(rsp_err),
      .div_start(div_start),
      .div_dividend(div_dividend),
      .div_divisor(div_divisor),
      .div_busy(div_busy),
      .div_quotient(div_quotient),
      .div_remainder(div_remainder)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Divider model: busy for ten cycles after start, results appear when busy falls
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         div_busy      <= 1'b0;
         mCnt          <= 4'd0;
         mA            <= 8'd0;
         mB            <= 8'd0;
         div_quotient  <= 8'd0;
         div_remainder <= 8'd0;
      end else if (div_start) begin
         div_busy <= (hangMode != 2);
         mCnt     <= 4'd9;
         mA       <= div_dividend;
         mB       <= div_divisor;
      end else if (div_busy && hangMode != 1) begin
         if (mCnt == 4'd0) begin
            div_busy      <= 1'b0;
            div_quotient  <= (mB != 0) ? mA / mB : 8'hFF;
            div_remainder <= (mB != 0) ? mA % mB : 8'hFF;
         end else begin
            mCnt <= mCnt - 4'd1;
         end
      end
   end

   // Absolute time bound so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no end of test, expected completion");
      $fatal(1, "[TB] simulation time bound exceeded");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int id, input logic [7:0] dvd, input logic [7:0] dvs);
      req[id]                  = 1'b1;
      req_dividend[8*id +: 8]  = dvd;
      req_divisor[8*id +: 8]   = dvs;
   endtask

   task automatic resetDut();
      reset = 1'b1;
      req   = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_gnt"},   gnt,           0);
      checkOutput({tag, "_vld"},   rsp_valid,     0);
      checkOutput({tag, "_id"},    rsp_id,        0);
      checkOutput({tag, "_q"},     rsp_quotient,  0);
      checkOutput({tag, "_r"},     rsp_remainder, 0);
      checkOutput({tag, "_dbz"},   rsp_dbz,       0);
      checkOutput({tag, "_err"},   rsp_err,       0);
      checkOutput({tag, "_start"}, div_start,     0);
      checkOutput({tag, "_dvd"},   div_dividend,  0);
      checkOutput({tag, "_dvs"},   div_divisor,   0);
   endtask

   // Called at the negedge of arbitration cycle T; ends at the negedge of T+latency
   task automatic doOp(input string tag, input int id, input logic [7:0] dvd, input logic [7:0] dvs,
                       input logic [7:0] expQ, input logic [7:0] expR, input logic expDbz,
                       input logic expErr, input int latency, input bit dropReq);
      int extraV;
      int extraG;
      int extraS;
      @(negedge clk);
      checkOutput({tag, "_gnt"},   gnt,          32'(1) << id);
      checkOutput({tag, "_start"}, div_start,    expDbz ? 0 : 1);
      checkOutput({tag, "_gid"},   rsp_id,       id);
      checkOutput({tag, "_gvld"},  rsp_valid,    0);
      checkOutput({tag, "_dvd"},   div_dividend, dvd);
      checkOutput({tag, "_dvs"},   div_divisor,  dvs);
      if (dropReq) req[id] = 1'b0;
      extraV = 0;
      extraG = 0;
      extraS = 0;
      for (int c = 2; c < latency; c++) begin
         @(negedge clk);
         if (rsp_valid) extraV++;
         if (|gnt) extraG++;
         if (div_start) extraS++;
      end
      checkOutput({tag, "_earlyvld"},   extraV, 0);
      checkOutput({tag, "_extragnt"},   extraG, 0);
      checkOutput({tag, "_extrastart"}, extraS, 0);
      @(negedge clk);
      checkOutput({tag, "_vld"},  rsp_valid,     1);
      checkOutput({tag, "_id"},   rsp_id,        id);
      checkOutput({tag, "_q"},    rsp_quotient,  expQ);
      checkOutput({tag, "_r"},    rsp_remainder, expR);
      checkOutput({tag, "_dbz"},  rsp_dbz,       expDbz);
      checkOutput({tag, "_err"},  rsp_err,       expErr);
      checkOutput({tag, "_vgnt"}, gnt,           0);
      checkOutput({tag, "_hold"}, div_dividend,  dvd);
   endtask

   // Directed sequence of operations with hand-computed results
   initial begin
      int quietG;
      int quietV;
      reset        = 1'b1;
      req          = '0;
      req_dividend = '0;
      req_divisor  = '0;
      @(negedge clk);
      @(negedge clk);
      checkAllZero("rst");
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle_gnt", gnt, 0);

      // Single request, 200/7 = 28 r 4
      applyStimulus(2, 8'd200, 8'd7);
      doOp("single", 2, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0, 13, 1'b1);

      // All four held high after reset: grants 0,1,2,3,0 spaced 13 cycles
      resetDut();
      for (int i = 0; i < NREQ; i++) applyStimulus(i, 8'd100, 8'(i + 1));
      doOp("rr0", 0, 8'd100, 8'd1, 8'd100, 8'd0, 1'b0, 1'b0, 13, 1'b0);
      doOp("rr1", 1, 8'd100, 8'd2, 8'd50,  8'd0, 1'b0, 1'b0, 13, 1'b0);
      doOp("rr2", 2, 8'd100, 8'd3, 8'd33,  8'd1, 1'b0, 1'b0, 13, 1'b0);
      doOp("rr3", 3, 8'd100, 8'd4, 8'd25,  8'd0, 1'b0, 1'b0, 13, 1'b0);
      doOp("rr4", 0, 8'd100, 8'd1, 8'd100, 8'd0, 1'b0, 1'b0, 13, 1'b0);
      req    = '0;
      quietG = 0;
      quietV = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (|gnt) quietG++;
         if (rsp_valid) quietV++;
      end
      checkOutput("dropped_gnt", quietG, 0);
      checkOutput("dropped_vld", quietV, 0);

      // Divide by zero answered locally
      applyStimulus(1, 8'd9, 8'd0);
      doOp("dbz", 1, 8'd9, 8'd0, 8'hFF, 8'hFF, 1'b1, 1'b0, 2, 1'b1);

      // Watchdog: busy stuck high, then busy never rising
      hangMode = 1;
      applyStimulus(0, 8'd10, 8'd3);
      doOp("wd_hi", 0, 8'd10, 8'd3, 8'hFF, 8'hFF, 1'b0, 1'b1, 2 + TIMEOUT, 1'b1);
      hangMode = 2;
      applyStimulus(2, 8'd10, 8'd3);
      doOp("wd_lo", 2, 8'd10, 8'd3, 8'hFF, 8'hFF, 1'b0, 1'b1, 2 + TIMEOUT, 1'b1);

      // Normal service resumes; edge operands
      hangMode = 0;
      applyStimulus(3, 8'd255, 8'd1);
      doOp("edge255", 3, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0, 13, 1'b1);
      applyStimulus(1, 8'd5, 8'd255);
      doOp("edge5", 1, 8'd5, 8'd255, 8'd0, 8'd5, 1'b0, 1'b0, 13, 1'b1);

      // Reset at T+6, then requester 3 alone
      applyStimulus(2, 8'd40, 8'd6);
      @(negedge clk);
      req = '0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      checkAllZero("midrstA");
      quietV = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (rsp_valid) quietV++;
      end
      checkOutput("midrstA_novld", quietV, 0);
      reset = 1'b0;
      applyStimulus(3, 8'd40, 8'd6);
      doOp("rstA", 3, 8'd40, 8'd6, 8'd6, 8'd4, 1'b0, 1'b0, 13, 1'b1);

      // Reset at T+6, then requesters 0 and 3 together: 0 first
      applyStimulus(1, 8'd60, 8'd7);
      @(negedge clk);
      req = '0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("midrstB_vld", rsp_valid, 0);
      checkOutput("midrstB_dvd", div_dividend, 0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(0, 8'd60, 8'd7);
      applyStimulus(3, 8'd77, 8'd8);
      doOp("rstB0", 0, 8'd60, 8'd7, 8'd8, 8'd4, 1'b0, 1'b0, 13, 1'b1);
      doOp("rstB3", 3, 8'd77, 8'd8, 8'd9, 8'd5, 1'b0, 1'b0, 13, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
